// File: rtl/servo_ramp_multi_if.sv
// Command port of servo_ramp_multi: one valid/ready transfer carries a
// channel index, a mode, a GOTO target and a per-tick step size.
interface servo_ramp_multi_if #(
  parameter int CH_W    = 2,
  parameter int ANGLE_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [CH_W-1:0]    cmd_ch;
  logic [1:0]         cmd_mode;
  logic [ANGLE_W-1:0] cmd_target;
  logic [3:0]         cmd_step;

  modport master (
    output cmd_valid, cmd_ch, cmd_mode, cmd_target, cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_mode, cmd_target, cmd_step,
    output cmd_ready
  );
endinterface

// File: rtl/servo_ramp_multi.sv
// Multi-channel servo angle generator: HOLD / GOTO / SWEEP per channel, all
// channels paced by one shared prescaler. Define SERVO_RAMP_PAUSE_EN to add a pause input.
module servo_ramp_multi #(
  parameter int CHANNELS  = 4,
  parameter int ANGLE_W   = 8,
  parameter int ANGLE_MIN = 0,
  parameter int ANGLE_MAX = 180,
  parameter int DIV_W     = 20,
  parameter int SPEED_DIV = 120000
) (
  input  logic                        clk,
  input  logic                        reset_n,
`ifdef SERVO_RAMP_PAUSE_EN
  input  logic                        pause,
`endif
  servo_ramp_multi_if.slave           cmd,
  output logic [CHANNELS*ANGLE_W-1:0] angle,
  output logic [CHANNELS-1:0]         dir,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         done
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SUM_W = ANGLE_W + 1;
  localparam logic [ANGLE_W-1:0] MIN_A    = ANGLE_W'(ANGLE_MIN);
  localparam logic [ANGLE_W-1:0] MAX_A    = ANGLE_W'(ANGLE_MAX);
  localparam logic [SUM_W-1:0]   MIN_X    = SUM_W'(ANGLE_MIN);
  localparam logic [SUM_W-1:0]   MAX_X    = SUM_W'(ANGLE_MAX);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SPEED_DIV - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_GOTO  = 2'd1,
    MODE_SWEEP = 2'd2
  } mode_t;

  logic [DIV_W-1:0]   div_cnt_reg;
  logic               cmd_ready_reg;
  logic               cmd_accept;
  logic               tick;
  logic               paused;
  logic [ANGLE_W-1:0] target_lo;
  logic [ANGLE_W-1:0] target_clamped;
  logic [3:0]         step_eff;

`ifdef SERVO_RAMP_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign tick       = !paused && (div_cnt_reg == DIV_LAST);
  assign cmd_accept = cmd.cmd_valid && cmd_ready_reg;
  assign cmd.cmd_ready = cmd_ready_reg;

  // Clamp written as max-then-min so a zero lower limit never yields a constant compare.
  assign target_lo      = (cmd.cmd_target > MIN_A) ? cmd.cmd_target : MIN_A;
  assign target_clamped = (target_lo < MAX_A) ? target_lo : MAX_A;
  assign step_eff       = (cmd.cmd_step == 4'd0) ? 4'd1 : cmd.cmd_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
    end else if (!paused) begin
      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
    end
  end

  // Ready is low for the single cycle after every accept, giving one command per two cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready_reg <= 1'b0;
    end else begin
      cmd_ready_reg <= !cmd_accept;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      mode_t              mode_reg;
      logic [ANGLE_W-1:0] angle_reg;
      logic [ANGLE_W-1:0] target_reg;
      logic [3:0]         step_reg;
      logic               dir_reg;
      logic               done_reg;
      logic               hit;
      logic [SUM_W-1:0]   angle_x;
      logic [SUM_W-1:0]   target_x;
      logic [SUM_W-1:0]   step_x;
      logic [SUM_W-1:0]   up_sum;
      logic [SUM_W-1:0]   down_diff;
      logic [ANGLE_W-1:0] goto_next;
      logic [ANGLE_W-1:0] sweep_next;
      logic               sweep_dir_next;

      assign hit       = cmd_accept && (cmd.cmd_ch == CH_W'(gi));
      assign angle_x   = {1'b0, angle_reg};
      assign target_x  = {1'b0, target_reg};
      assign step_x    = SUM_W'(step_reg);
      assign up_sum    = angle_x + step_x;
      assign down_diff = angle_x - step_x;

      // One-bit-wider sums let the limit tests see past the ends without wrapping.
      always_comb begin
        goto_next      = target_reg;
        sweep_next     = angle_reg;
        sweep_dir_next = dir_reg;
        if (angle_reg < target_reg) begin
          goto_next = (up_sum >= target_x) ? target_reg : up_sum[ANGLE_W-1:0];
        end else if (angle_reg > target_reg) begin
          goto_next = (angle_x <= target_x + step_x) ? target_reg : down_diff[ANGLE_W-1:0];
        end
        if (!dir_reg) begin
          if (up_sum >= MAX_X) begin
            sweep_next     = MAX_A;
            sweep_dir_next = 1'b1;
          end else begin
            sweep_next = up_sum[ANGLE_W-1:0];
          end
        end else begin
          if (angle_x <= MIN_X + step_x) begin
            sweep_next     = MIN_A;
            sweep_dir_next = 1'b0;
          end else begin
            sweep_next = down_diff[ANGLE_W-1:0];
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mode_reg   <= MODE_HOLD;
          angle_reg  <= MIN_A;
          target_reg <= MIN_A;
          step_reg   <= 4'd1;
          dir_reg    <= 1'b0;
          done_reg   <= 1'b0;
        end else begin
          done_reg <= 1'b0;
          if (hit) begin
            target_reg <= target_clamped;
            step_reg   <= step_eff;
            case (cmd.cmd_mode)
              2'd0: mode_reg <= MODE_HOLD;
              2'd1: begin
                dir_reg <= (target_clamped < angle_reg);
                if (target_clamped == angle_reg) begin
                  done_reg <= 1'b1;
                  mode_reg <= MODE_HOLD;
                end else begin
                  mode_reg <= MODE_GOTO;
                end
              end
              2'd2: begin
                mode_reg <= MODE_SWEEP;
                if (angle_reg == MIN_A) begin
                  dir_reg <= 1'b0;
                end else if (angle_reg == MAX_A) begin
                  dir_reg <= 1'b1;
                end
              end
              default: begin
                mode_reg  <= MODE_HOLD;
                angle_reg <= MIN_A;
                dir_reg   <= 1'b0;
              end
            endcase
          end else if (tick) begin
            case (mode_reg)
              MODE_GOTO: begin
                angle_reg <= goto_next;
                if (goto_next == target_reg) begin
                  done_reg <= 1'b1;
                  mode_reg <= MODE_HOLD;
                end
              end
              MODE_SWEEP: begin
                angle_reg <= sweep_next;
                dir_reg   <= sweep_dir_next;
              end
              default: ;
            endcase
          end
        end
      end

      assign angle[gi*ANGLE_W +: ANGLE_W] = angle_reg;
      assign dir[gi]  = dir_reg;
      assign busy[gi] = (mode_reg != MODE_HOLD);
      assign done[gi] = done_reg;
    end
  endgenerate

endmodule
